kes_sched: RTL and testbench

//  Shares one kes (RiBM key-equation solver) instance between NCH syndrome producers.

---
 rtl/kes_sched_if.sv | 37 +++
 rtl/kes_sched.sv | 162 ++++++++++++++++
 tb/tb_kes_sched.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kes_sched_if.sv
// Bundles the syndrome request, kes and result channels of the kes scheduler.
interface kes_sched_if #(
  parameter int unsigned SYM_BW = 8,
  parameter int unsigned R_NUM  = 16,
  parameter int unsigned T_NUM  = R_NUM / 2,
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_BW  = 2
);
  logic [NCH-1:0]              syn_vld;
  logic [NCH-1:0]              syn_rdy;
  logic [NCH*R_NUM*SYM_BW-1:0] syn_data;
  logic                        kes_start;
  logic [R_NUM*SYM_BW-1:0]     kes_syndrome;
  logic [(T_NUM+1)*SYM_BW-1:0] kes_lamda;
  logic [T_NUM*SYM_BW-1:0]     kes_omega;
  logic                        kes_done;
  logic                        out_vld;
  logic                        out_rdy;
  logic [CH_BW-1:0]            out_ch;
  logic [(T_NUM+1)*SYM_BW-1:0] out_lamda;
  logic [T_NUM*SYM_BW-1:0]     out_omega;
  logic                        out_zero;
  logic                        out_err;
  logic                        busy;

  modport master (
    output syn_vld, syn_data, kes_lamda, kes_omega, kes_done, out_rdy,
    input  syn_rdy, kes_start, kes_syndrome, out_vld, out_ch, out_lamda,
           out_omega, out_zero, out_err, busy
  );

  modport slave (
    input  syn_vld, syn_data, kes_lamda, kes_omega, kes_done, out_rdy,
    output syn_rdy, kes_start, kes_syndrome, out_vld, out_ch, out_lamda,
           out_omega, out_zero, out_err, busy
  );
endinterface

// File: rtl/kes_sched.sv
// Round-robin scheduler sharing one RiBM kes between NCH syndrome producers,
// with zero-syndrome bypass and a watchdog on the kes result.
module kes_sched #(
  parameter int unsigned SYM_BW = 8,
  parameter int unsigned R_NUM  = 16,
  parameter int unsigned T_NUM  = R_NUM / 2,
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_BW  = 2,
  parameter int unsigned TO_CYC = 32
) (
  input logic       clk,
  input logic       rst_n,
  kes_sched_if.slave bus
);
  localparam int unsigned SYN_W = R_NUM * SYM_BW;
  localparam int unsigned LAM_W = (T_NUM + 1) * SYM_BW;
  localparam int unsigned OMG_W = T_NUM * SYM_BW;
  localparam int unsigned TMR_W = $clog2(TO_CYC);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [CH_BW-1:0] ptr_q, ptr_d;
  logic [CH_BW-1:0] ch_q, ch_d;
  logic [SYN_W-1:0] syn_q, syn_d;
  logic [LAM_W-1:0] lam_q, lam_d;
  logic [OMG_W-1:0] omg_q, omg_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             vld_q, vld_d;
  logic             start_q, start_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             gnt_found;
  logic [CH_BW-1:0] gnt_ch;
  logic [SYN_W-1:0] gnt_syn;

  // Scan from ptr upward with an explicit wrap so NCH need not be a power of 2.
  always_comb begin : arb
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    gnt_syn   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_found && bus.syn_vld[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = CH_BW'(idx);
        gnt_syn   = bus.syn_data[idx*SYN_W +: SYN_W];
      end
    end
  end

  always_comb begin
    bus.syn_rdy = '0;
    if (rst_n && state_q == S_IDLE && gnt_found) bus.syn_rdy = NCH'(1) << gnt_ch;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    syn_d   = syn_q;
    lam_d   = lam_q;
    omg_d   = omg_q;
    zero_d  = zero_q;
    err_d   = err_q;
    vld_d   = vld_q;
    start_d = 1'b0;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          syn_d = gnt_syn;
          ch_d  = gnt_ch;
          if (gnt_syn == '0) begin
            lam_d   = LAM_W'(1);
            omg_d   = '0;
            zero_d  = 1'b1;
            err_d   = 1'b0;
            vld_d   = 1'b1;
            state_d = S_OUT;
          end else begin
            zero_d  = 1'b0;
            start_d = 1'b1;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the final watchdog cycle still counts as success.
        if (bus.kes_done) begin
          lam_d   = bus.kes_lamda;
          omg_d   = bus.kes_omega;
          err_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = S_OUT;
        end else if (tmr_q == TMR_W'(TO_CYC - 1)) begin
          lam_d   = '0;
          omg_d   = '0;
          err_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_OUT: begin
        if (bus.out_rdy) begin
          vld_d   = 1'b0;
          ptr_d   = (ch_q == CH_BW'(NCH - 1)) ? '0 : ch_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      syn_q   <= '0;
      lam_q   <= '0;
      omg_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      syn_q   <= syn_d;
      lam_q   <= lam_d;
      omg_q   <= omg_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      start_q <= start_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.kes_start    = start_q;
  assign bus.kes_syndrome = syn_q;
  assign bus.out_vld      = vld_q;
  assign bus.out_ch       = ch_q;
  assign bus.out_lamda    = lam_q;
  assign bus.out_omega    = omg_q;
  assign bus.out_zero     = zero_q;
  assign bus.out_err      = err_q;
  assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_kes_sched.sv
// Scoreboard bench for kes_sched: a kes stub answers with a fixed function of the
// latched syndrome, and a reference model predicts grants, timing and results.
module tb_kes_sched;
  localparam int SYM_BW = 8;
  localparam int R_NUM  = 16;
  localparam int T_NUM  = 8;
  localparam int NCH    = 4;
  localparam int CH_BW  = 2;
  localparam int TO_CYC = 32;
  localparam int SW = R_NUM * SYM_BW;
  localparam int LW = (T_NUM + 1) * SYM_BW;
  localparam int OW = T_NUM * SYM_BW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  kes_sched_if #(.SYM_BW(SYM_BW), .R_NUM(R_NUM), .T_NUM(T_NUM), .NCH(NCH), .CH_BW(CH_BW)) bus();

  kes_sched #(.SYM_BW(SYM_BW), .R_NUM(R_NUM), .T_NUM(T_NUM), .NCH(NCH), .CH_BW(CH_BW),
              .TO_CYC(TO_CYC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int             ch;
    logic [LW-1:0]  lam;
    logic [OW-1:0]  om;
    logic           zero;
    logic           err;
    longint         vld_cyc;
  } exp_t;

  exp_t          q[$];
  longint        cyc = 0;
  int            n_chk = 0;
  int            n_err = 0;
  int            n_acc = 0;
  bit            m_busy = 0;
  int            m_ptr = 0;
  longint        exp_start = -1;
  logic [SW-1:0] cur_syn = '0;
  bit            hang = 0;
  bit            taken [NCH];
  logic          req_vld [NCH];
  logic [SW-1:0] req_data [NCH];

  always_comb begin
    bus.syn_vld  = '0;
    bus.syn_data = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.syn_vld[c]             = req_vld[c];
      bus.syn_data[c*SW +: SW]   = req_data[c];
    end
  end

  function automatic logic [LW-1:0] f_lam(input logic [SW-1:0] s);
    logic [2*SW-1:0] d;
    d = {s, s} >> 5;
    return LW'(d) ^ LW'(s >> 60) ^ 72'h5a_0123456789abcdef;
  endfunction

  function automatic logic [OW-1:0] f_om(input logic [SW-1:0] s);
    return OW'(s >> 37) ^ OW'(s) ^ 64'h3c3c_3c3c_3c3c_3c3c;
  endfunction

  function automatic logic [SW-1:0] rnd_nz();
    logic [SW-1:0] v;
    v = '0;
    while (v == '0) v = {$urandom(), $urandom(), $urandom(), $urandom()};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s @cyc %0d: wait expired, got no completion, required completion", nm, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // kes stub: answers 2*T_NUM+1 cycles after start, sprays ignored done pulses otherwise
  initial begin : kes_stub
    bit            pend;
    longint        done_at;
    logic [SW-1:0] lat;
    pend = 0; done_at = 0; lat = '0;
    bus.kes_done = 1'b0; bus.kes_lamda = '0; bus.kes_omega = '0;
    forever begin
      @(posedge clk); #1;
      bus.kes_done  = 1'b0;
      bus.kes_lamda = LW'({$urandom(), $urandom(), $urandom()});
      bus.kes_omega = OW'({$urandom(), $urandom()});
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend && cyc == done_at) begin
          bus.kes_done  = 1'b1;
          bus.kes_lamda = f_lam(lat);
          bus.kes_omega = f_om(lat);
          pend = 0;
        end else if (!pend && !bus.kes_start && !hang && $urandom_range(7) == 0) begin
          bus.kes_done = 1'b1;
        end
        if (bus.kes_start && !hang) begin
          pend    = 1;
          lat     = bus.kes_syndrome;
          done_at = cyc + 2 * T_NUM + 1;
        end
      end
    end
  end

  initial begin : monitor
    exp_t           it;
    int             g;
    int             c;
    logic [NCH-1:0] exp_rdy;
    bit             ov;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_busy = 0; m_ptr = 0; exp_start = -1;
        for (int k = 0; k < NCH; k++) taken[k] = 0;
        chk("rst_ctrl", 128'({bus.out_vld, bus.busy, bus.kes_start, bus.out_zero, bus.out_err,
                              bus.out_ch, bus.syn_rdy}), 128'(0));
        chk("rst_lamda", 128'(bus.out_lamda), 128'(0));
        chk("rst_omega", 128'(bus.out_omega), 128'(0));
        chk("rst_syndrome", 128'(bus.kes_syndrome), 128'(0));
      end else begin
        chk("busy", 128'(bus.busy), 128'(m_busy));
        chk("kes_start", 128'(bus.kes_start), 128'(cyc == exp_start));
        if (m_busy) chk("kes_syndrome", 128'(bus.kes_syndrome), 128'(cur_syn));
        g = -1;
        exp_rdy = '0;
        if (!m_busy)
          for (int k = 0; k < NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (g < 0 && bus.syn_vld[c]) g = c;
          end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("syn_rdy", 128'(bus.syn_rdy), 128'(exp_rdy));
        for (int k = 0; k < NCH; k++) if (bus.syn_rdy[k] && bus.syn_vld[k]) taken[k] = 1;
        if (g >= 0) begin
          cur_syn = req_data[g];
          it.ch = g;
          if (cur_syn == '0) begin
            it.lam = LW'(1); it.om = '0; it.zero = 1; it.err = 0;
            it.vld_cyc = cyc + 1;
          end else if (hang) begin
            it.lam = '0; it.om = '0; it.zero = 0; it.err = 1;
            it.vld_cyc = cyc + TO_CYC + 2;
            exp_start = cyc + 1;
          end else begin
            it.lam = f_lam(cur_syn); it.om = f_om(cur_syn); it.zero = 0; it.err = 0;
            it.vld_cyc = cyc + 2 * T_NUM + 3;
            exp_start = cyc + 1;
          end
          q.push_back(it);
          m_busy = 1;
          n_acc++;
        end
        ov = (q.size() > 0) && (cyc >= q[0].vld_cyc);
        chk("out_vld", 128'(bus.out_vld), 128'(ov));
        if (ov) begin
          chk("out_ch", 128'(bus.out_ch), 128'(q[0].ch));
          chk("out_lamda", 128'(bus.out_lamda), 128'(q[0].lam));
          chk("out_omega", 128'(bus.out_omega), 128'(q[0].om));
          chk("out_zero_err", 128'({bus.out_zero, bus.out_err}), 128'({q[0].zero, q[0].err}));
          if (bus.out_rdy) begin
            m_ptr = (q[0].ch + 1) % NCH;
            void'(q.pop_front());
            m_busy = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    for (int c = 0; c < NCH; c++)
      if (taken[c]) begin
        req_vld[c] = 1'b0;
        taken[c]   = 0;
      end
  endtask

  task automatic raise(input int c, input logic [SW-1:0] d);
    req_data[c] = d;
    req_vld[c]  = 1'b1;
  endtask

  function automatic bit all_idle();
    bit r;
    r = (q.size() == 0) && !m_busy;
    for (int c = 0; c < NCH; c++) if (req_vld[c]) r = 0;
    return r;
  endfunction

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    if (!all_idle()) expire(nm);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int a0;
    for (int c = 0; c < NCH; c++) begin
      req_vld[c] = 1'b0; req_data[c] = '0; taken[c] = 0;
    end
    bus.out_rdy = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single nonzero codeword on ch1
    bus.out_rdy = 1'b1;
    raise(1, rnd_nz());
    wait_done("single_ch1", 60);

    // all four requesters held valid
    for (int c = 0; c < NCH; c++) raise(c, rnd_nz());
    a0 = n_acc; n = 0;
    while (n_acc - a0 < 5 && n < 200) begin
      step();
      for (int c = 0; c < NCH; c++) if (!req_vld[c]) raise(c, rnd_nz());
      n++;
    end
    if (n_acc - a0 < 5) expire("rr_five_grants");
    wait_done("rr_drain", 200);

    // zero-syndrome bypass on ch2
    raise(2, '0);
    wait_done("zero_bypass", 20);

    // kes never answers
    hang = 1;
    raise(0, rnd_nz());
    wait_done("watchdog_timeout", 80);
    hang = 0;

    // back-pressure in OUT with competing requests
    bus.out_rdy = 1'b0;
    raise(1, rnd_nz());
    n = 0;
    while (!bus.out_vld && n < 40) begin step(); n++; end
    if (!bus.out_vld) expire("reach_out");
    raise(0, rnd_nz());
    raise(3, rnd_nz());
    repeat (10) step();
    bus.out_rdy = 1'b1;
    wait_done("backpressure", 100);

    // asynchronous reset while waiting on kes
    raise(2, rnd_nz());
    n = 0;
    while (!bus.kes_start && n < 10) begin step(); n++; end
    if (!bus.kes_start) expire("reach_start");
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 128'({bus.out_vld, bus.busy, bus.kes_start, bus.syn_rdy}), 128'(0));
    chk("async_rst_lamda", 128'(bus.out_lamda), 128'(0));
    chk("async_rst_syndrome", 128'(bus.kes_syndrome), 128'(0));
    raise(1, rnd_nz());
    raise(3, rnd_nz());
    repeat (3) step();
    rst_n = 1'b1;
    wait_done("post_reset", 100);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.out_rdy = ($urandom_range(3) != 0);
      for (int c = 0; c < NCH; c++) begin
        if (!req_vld[c]) begin
          if ($urandom_range(4) == 0) raise(c, ($urandom_range(5) == 0) ? SW'(0) : rnd_nz());
        end else if ($urandom_range(19) == 0) begin
          req_vld[c] = 1'b0;
        end
      end
    end
    bus.out_rdy = 1'b1;
    wait_done("random_drain", 200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
